// File: rtl/ceespu_dmem_arbiter_if.sv
// Bundle of the CPU, auxiliary-master and RAM-side signals around the dmem arbiter.
// The arbiter takes the slave view; masters and the RAM model take the master view.
interface ceespu_dmem_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              cpu_en;
  logic [3:0]        cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_busy;

  logic              aux_req;
  logic [3:0]        aux_we;
  logic [ADDR_W-1:0] aux_addr;
  logic [31:0]       aux_wdata;
  logic              aux_gnt;
  logic              aux_rvalid;
  logic [31:0]       aux_rdata;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  cpu_en, cpu_we, cpu_addr, cpu_wdata,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_busy,
    output aux_gnt, aux_rvalid, aux_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_en, cpu_we, cpu_addr, cpu_wdata,
    output aux_req, aux_we, aux_addr, aux_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_busy,
    input  aux_gnt, aux_rvalid, aux_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ceespu_dmem_arbiter.sv
// Single-port RAM arbiter: CPU has fixed priority, aux is forced through after STARVE_LIMIT lost contests.
// Grant is combinational; read data returns one cycle after accept; a losing master sees busy/no-gnt and holds.
module ceespu_dmem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  ceespu_dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_AUX  = 2'd2
  } owner_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  owner_t           rd_owner;
  logic [31:0]      cpu_rdata_q;
  logic [31:0]      aux_rdata_q;

  logic both_req;
  logic aux_wins;
  logic cpu_wins;
  logic unused_addr_lsbs;

  // Byte lanes are selected by we, so the sub-word address bits carry no information here.
  assign unused_addr_lsbs = ^{bus.cpu_addr[1:0], bus.aux_addr[1:0]};

  always_comb begin
    both_req = bus.cpu_en & bus.aux_req;
    aux_wins = ~rst & bus.aux_req & (~bus.cpu_en | (starve_cnt >= LIMIT));
    cpu_wins = ~rst & bus.cpu_en & ~aux_wins;

    bus.cpu_busy = bus.cpu_en & ~cpu_wins;
    bus.aux_gnt  = aux_wins;

    bus.mem_en    = 1'b0;
    bus.mem_we    = 4'b0000;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (aux_wins) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.aux_we;
      bus.mem_addr  = bus.aux_addr[ADDR_W-1:2];
      bus.mem_wdata = bus.aux_wdata;
    end else if (cpu_wins) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr[ADDR_W-1:2];
      bus.mem_wdata = bus.cpu_wdata;
    end

    // RAM output is forwarded in the return cycle so neither master pays an extra cycle.
    bus.cpu_rdata  = (rd_owner == OWN_CPU) ? bus.mem_rdata : cpu_rdata_q;
    bus.aux_rdata  = (rd_owner == OWN_AUX) ? bus.mem_rdata : aux_rdata_q;
    bus.aux_rvalid = (rd_owner == OWN_AUX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt  <= '0;
      rd_owner    <= OWN_NONE;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
    end else begin
      if (aux_wins) begin
        starve_cnt <= '0;
      end else if (both_req && (starve_cnt < LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      if (cpu_wins && (bus.cpu_we == 4'b0000)) begin
        rd_owner <= OWN_CPU;
      end else if (aux_wins && (bus.aux_we == 4'b0000)) begin
        rd_owner <= OWN_AUX;
      end else begin
        rd_owner <= OWN_NONE;
      end

      if (rd_owner == OWN_CPU) begin
        cpu_rdata_q <= bus.mem_rdata;
      end
      if (rd_owner == OWN_AUX) begin
        aux_rdata_q <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ceespu_dmem_arbiter.sv
// Vector-driven bench for ceespu_dmem_arbiter with a behavioural RAM and a read-return scoreboard.
module tb_ceespu_dmem_arbiter;

  localparam int W_NONE = 0;
  localparam int W_CPU  = 1;
  localparam int W_AUX  = 2;

  typedef struct {
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        aux_req;
    logic [3:0]  aux_we;
    logic [15:0] aux_addr;
    logic [31:0] aux_wdata;
    int          win;
  } vec_t;

  typedef struct {
    bit          is_aux;
    logic [31:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ceespu_dmem_arbiter_if #(.ADDR_W(16)) bus ();

  ceespu_dmem_arbiter #(
    .ADDR_W(16),
    .STARVE_LIMIT(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] ram    [0:16383];
  logic [31:0] shadow [0:16383];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
      if (bus.mem_we == 4'b0000) bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  int          n_cmp  = 0;
  int          n_fail = 0;
  rd_t         sb[$];
  logic [31:0] cpu_hold;
  logic [31:0] aux_hold;
  vec_t        tbl[$];
  vec_t        seq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic ce, input logic [3:0] cwe,
                              input logic [15:0] ca, input logic [31:0] cd,
                              input logic ar, input logic [3:0] awe,
                              input logic [15:0] aa, input logic [31:0] ad, input int w);
    vec_t v;
    v.rst = r; v.cpu_en = ce; v.cpu_we = cwe; v.cpu_addr = ca; v.cpu_wdata = cd;
    v.aux_req = ar; v.aux_we = awe; v.aux_addr = aa; v.aux_wdata = ad; v.win = w;
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Drive one cycle; entered and left at posedge+1.
  task automatic apply(input vec_t v);
    logic [3:0]  ewe;
    logic [15:0] eaddr;
    logic [31:0] ewd;
    rd_t         p;
    bit          has_p;
    rst           = v.rst;
    bus.cpu_en    = v.cpu_en;    bus.cpu_we = v.cpu_we;
    bus.cpu_addr  = v.cpu_addr;  bus.cpu_wdata = v.cpu_wdata;
    bus.aux_req   = v.aux_req;   bus.aux_we = v.aux_we;
    bus.aux_addr  = v.aux_addr;  bus.aux_wdata = v.aux_wdata;
    @(negedge clk);

    has_p = (sb.size() > 0);
    if (has_p) p = sb.pop_front();
    if (!v.rst) begin
      if (has_p && !p.is_aux) begin
        chk("cpu_rdata_return", bus.cpu_rdata, p.data);
        chk("aux_rvalid_idle", {31'b0, bus.aux_rvalid}, 32'd0);
        chk("aux_rdata_hold", bus.aux_rdata, aux_hold);
        cpu_hold = p.data;
      end else if (has_p) begin
        chk("aux_rvalid_return", {31'b0, bus.aux_rvalid}, 32'd1);
        chk("aux_rdata_return", bus.aux_rdata, p.data);
        chk("cpu_rdata_hold", bus.cpu_rdata, cpu_hold);
        aux_hold = p.data;
      end else begin
        chk("aux_rvalid_idle", {31'b0, bus.aux_rvalid}, 32'd0);
        chk("cpu_rdata_hold", bus.cpu_rdata, cpu_hold);
        chk("aux_rdata_hold", bus.aux_rdata, aux_hold);
      end
    end else begin
      sb.delete();
      cpu_hold = 32'd0;
      aux_hold = 32'd0;
    end

    chk("cpu_busy", {31'b0, bus.cpu_busy}, {31'b0, v.cpu_en & (v.win != W_CPU)});
    chk("aux_gnt", {31'b0, bus.aux_gnt}, {31'b0, v.aux_req & (v.win == W_AUX)});
    chk("mem_en", {31'b0, bus.mem_en}, {31'b0, v.win != W_NONE});
    if (v.win != W_NONE) begin
      ewe   = (v.win == W_CPU) ? v.cpu_we    : v.aux_we;
      eaddr = (v.win == W_CPU) ? v.cpu_addr  : v.aux_addr;
      ewd   = (v.win == W_CPU) ? v.cpu_wdata : v.aux_wdata;
      chk("mem_we", {28'b0, bus.mem_we}, {28'b0, ewe});
      chk("mem_addr", {18'b0, bus.mem_addr}, {18'b0, eaddr[15:2]});
      chk("mem_wdata", bus.mem_wdata, ewd);
      if (ewe == 4'b0000) begin
        p.is_aux = (v.win == W_AUX);
        p.data   = shadow[eaddr[15:2]];
        sb.push_back(p);
      end else begin
        shadow[eaddr[15:2]] = merge(shadow[eaddr[15:2]], ewd, ewe);
      end
    end else begin
      chk("mem_we_idle", {28'b0, bus.mem_we}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle, both_rd, cpu_rd;
    for (int i = 0; i < 16384; i++) begin
      ram[i] = 32'd0;
      shadow[i] = 32'd0;
    end
    ram[16] = 32'hDEADBEEF; shadow[16] = 32'hDEADBEEF;
    ram[17] = 32'hAAAAAAAA; shadow[17] = 32'hAAAAAAAA;
    ram[2]  = 32'hA5A5A5A5; shadow[2]  = 32'hA5A5A5A5;
    cpu_hold = 32'd0;
    aux_hold = 32'd0;

    idle    = mk(0, 0, 4'h0, 16'h0000, 32'h0, 0, 4'h0, 16'h0000, 32'h0, W_NONE);
    both_rd = mk(0, 1, 4'h0, 16'h0040, 32'h0, 1, 4'h0, 16'h0008, 32'h0, W_CPU);
    cpu_rd  = mk(0, 1, 4'h0, 16'h0040, 32'h0, 0, 4'h0, 16'h0000, 32'h0, W_CPU);

    rst = 1'b1;
    bus.cpu_en = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.aux_req = 0; bus.aux_we = 0; bus.aux_addr = 0; bus.aux_wdata = 0;
    @(posedge clk);
    #1;

    // Reset with both masters requesting, then idle checks of the cleared state.
    tbl.push_back(mk(1, 1, 4'h0, 16'h0040, 32'h0, 1, 4'h0, 16'h0008, 32'h0, W_NONE));
    tbl.push_back(mk(1, 1, 4'h0, 16'h0040, 32'h0, 1, 4'h0, 16'h0008, 32'h0, W_NONE));
    tbl.push_back(idle);
    tbl.push_back(cpu_rd);
    tbl.push_back(idle);
    tbl.push_back(idle);
    tbl.push_back(mk(0, 1, 4'b0011, 16'h0044, 32'h12345678, 0, 4'h0, 16'h0, 32'h0, W_CPU));
    tbl.push_back(mk(0, 1, 4'h0, 16'h0047, 32'h0, 0, 4'h0, 16'h0, 32'h0, W_CPU));
    tbl.push_back(mk(0, 0, 4'h0, 16'h0, 32'h0, 1, 4'h0, 16'h0008, 32'h0, W_AUX));
    tbl.push_back(idle);
    tbl.push_back(mk(0, 0, 4'h0, 16'h0, 32'h0, 1, 4'b1100, 16'h000B, 32'h11223344, W_AUX));
    tbl.push_back(mk(0, 1, 4'h0, 16'h0008, 32'h0, 0, 4'h0, 16'h0, 32'h0, W_CPU));
    tbl.push_back(mk(0, 1, 4'h0, 16'h0040, 32'h0, 1, 4'h0, 16'h0044, 32'h0, W_CPU));
    tbl.push_back(mk(0, 0, 4'h0, 16'h0, 32'h0, 1, 4'h0, 16'h0044, 32'h0, W_AUX));
    tbl.push_back(idle);
    foreach (tbl[i]) apply(tbl[i]);

    // Counter holds while aux is idle: 2 contests, 3 cpu-only, 2 contests, then aux forced.
    seq.push_back(both_rd); seq.push_back(both_rd);
    seq.push_back(cpu_rd);  seq.push_back(cpu_rd);  seq.push_back(cpu_rd);
    seq.push_back(both_rd); seq.push_back(both_rd);
    seq.push_back(mk(0, 1, 4'h0, 16'h0040, 32'h0, 1, 4'h0, 16'h0008, 32'h0, W_AUX));
    // Continuous contention: aux wins every fifth cycle.
    for (int k = 0; k < 10; k++) begin
      vec_t v;
      v = both_rd;
      if (k == 4 || k == 9) v.win = W_AUX;
      seq.push_back(v);
    end
    seq.push_back(idle);
    // Reset while both request, with the counter partly advanced.
    seq.push_back(both_rd); seq.push_back(both_rd);
    seq.push_back(mk(1, 1, 4'h0, 16'h0040, 32'h0, 1, 4'h0, 16'h0008, 32'h0, W_NONE));
    seq.push_back(idle);
    for (int k = 0; k < 5; k++) begin
      vec_t v;
      v = both_rd;
      if (k == 4) v.win = W_AUX;
      seq.push_back(v);
    end
    seq.push_back(idle);
    seq.push_back(idle);
    foreach (seq[i]) apply(seq[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ceespu_dmem_arbiter.md
Name: ceespu_dmem_arbiter

Overview:
Shares one single-port synchronous data RAM between the ceespu data port and an auxiliary master (boot loader / DMA).
- CPU has fixed priority.
- A starvation counter guarantees the auxiliary master a slot after a bounded wait.
- The block sits between the core's dmem interface and the RAM macro. It routes address, write data and byte enables, and steers read data back to the owning master.

Parameters:
ADDR_W, 16, byte-address width of both masters; RAM word address = addr[ADDR_W-1:2]
STARVE_LIMIT, 4, contested cycles aux may lose before it is forced to win
CNT_W, 3, width of starvation counter (must hold STARVE_LIMIT)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cpu_en  in  1  CPU data request (read if cpu_we==0)
cpu_we  in  4  CPU byte write enables
cpu_addr  in  ADDR_W  CPU byte address
cpu_wdata  in  32  CPU write data
cpu_rdata  out  32  CPU read data
cpu_busy  out  1  CPU request not accepted this cycle; CPU holds request stable
aux_req  in  1  aux request
aux_we  in  4  aux byte write enables
aux_addr  in  ADDR_W  aux byte address
aux_wdata  in  32  aux write data
aux_gnt  out  1  aux request accepted this cycle
aux_rvalid  out  1  aux read data valid
aux_rdata  out  32  aux read data
mem_en  out  1  RAM enable
mem_we  out  4  RAM byte write enables
mem_addr  out  ADDR_W-2  RAM word address
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data, valid the cycle after a read is issued

Behaviour:
- Reset: synchronous, active-high, on clk. It clears the following registered state:
  - starvation counter = 0
  - rd_owner = NONE
  - cpu_rdata_q = 0, aux_rdata_q = 0
  - aux_rvalid = 0
- While rst is high:
  - mem_en=0, mem_we=0, aux_gnt=0.
  - cpu_busy = cpu_en.
  - mem_addr/mem_wdata are don't-care, driven 0.
- Arbitration is combinational within the cycle. Winner:
  - aux only: aux wins.
  - cpu only: cpu wins.
  - both, counter < STARVE_LIMIT: cpu wins; counter += 1.
  - both, counter == STARVE_LIMIT: aux wins.
- Starvation counter:
  - Clears on any aux grant.
  - Holds when aux_req is low.
  - Saturates at STARVE_LIMIT (never wraps).
- Winner routing:
  - The winner's we/addr[ADDR_W-1:2]/wdata drive the RAM; mem_en=1.
  - No request: mem_en=0, mem_we=0.
- Handshake outputs:
  - cpu_busy = cpu_en & ~cpu_wins.
  - aux_gnt = aux_req & aux_wins.
  - Accept = CPU: cpu_en & ~cpu_busy. Accept = aux: aux_gnt.
- Read (accepted request with we==0):
  - rd_owner is registered for the next cycle. Writes set rd_owner=NONE.
- Return cycle (rd_owner==CPU): cpu_rdata = mem_rdata (combinational pass-through); cpu_rdata_q captures mem_rdata.
- Other cycles: cpu_rdata = cpu_rdata_q (held until the next CPU read returns).
- rd_owner==AUX:
  - aux_rvalid=1 for exactly one cycle.
  - aux_rdata = mem_rdata; aux_rdata_q captures it.
  - Otherwise aux_rdata = aux_rdata_q, aux_rvalid=0.
- Throughput: back-to-back accepts are allowed every cycle. Read latency is 1 cycle after accept for both masters.
- Address alignment: addr[1:0] are ignored. Byte-lane selection is the master's responsibility via we.
- Partial write enables are passed unmodified.
- Reset mid-read: a read accepted in the cycle rst rises produces no aux_rvalid and does not update cpu_rdata_q.
- Masters must hold a rejected request stable. The arbiter stores no request state beyond the counter.

Test Plan:
- Reset: rst=1 for 2 cycles with cpu_en=1 → mem_en=0, cpu_busy=1, aux_gnt=0. Then rst=0 → cpu_rdata=0, aux_rvalid=0, counter=0.
- CPU-only read: preload RAM word 0x10=0xDEADBEEF; cpu_en=1, we=0, addr=0x0040 → same cycle mem_en=1, mem_addr=0x10, cpu_busy=0. Next cycle cpu_rdata=0xDEADBEEF, held after cpu_en drops.
- CPU byte write: cpu_we=4'b0011, addr=0x0044, wdata=0x12345678 → mem_we=0011, mem_addr=0x11; no rvalid. Read back gives low halfword 0x5678.
- Contention/starvation, STARVE_LIMIT=4: cpu_en and aux_req high continuously → cpu wins cycles 1-4. Cycle 5: aux_gnt=1, cpu_busy=1. Cycles 6-9: cpu wins again; aux granted again at cycle 10.
- Aux-only read: aux_req=1, addr=0x0008, RAM word 2=0xA5A5A5A5 → aux_gnt=1 same cycle. Next cycle aux_rvalid=1 for one cycle, aux_rdata=0xA5A5A5A5. cpu_rdata unchanged.
- Reset mid-operation: aux read accepted in the same cycle rst=1 → the next cycle shows aux_rvalid=0 and counter=0.
